// File: rtl/card_pkg.sv
// Card codes, 7-segment glyphs (active-low, g..a) and baccarat scoring helpers
// shared by the hand display and its glyph decoder.
package card_pkg;

  typedef logic [3:0] card_t;
  typedef logic [6:0] seg_t;

  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_NINE  = 4'd9;
  localparam card_t CARD_TEN   = 4'd10;
  localparam card_t CARD_JACK  = 4'd11;
  localparam card_t CARD_QUEEN = 4'd12;
  localparam card_t CARD_KING  = 4'd13;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_ACE   = 7'b0001000;
  localparam seg_t SEG_JACK  = 7'b1100001;
  localparam seg_t SEG_QUEEN = 7'b0011000;
  localparam seg_t SEG_KING  = 7'b0001001;

  function automatic logic card_is_valid(input card_t c);
    return (c >= CARD_ACE) && (c <= CARD_KING);
  endfunction

  // Ten and court cards count zero in baccarat.
  function automatic logic [3:0] card_points(input card_t c);
    if ((c >= CARD_ACE) && (c <= CARD_NINE)) return c;
    return 4'd0;
  endfunction

  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

endpackage

// File: rtl/card_glyph.sv
// Decodes a card code (mode=0) or a score digit 0..9 (mode=1) to an active-low
// g..a glyph; purely combinational, unknown codes decode to blank.
module card_glyph
  import card_pkg::*;
(
  input  logic  mode,
  input  card_t code,
  output seg_t  seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:       seg = mode ? SEG_0 : SEG_BLANK;
      4'd1:       seg = mode ? SEG_1 : SEG_ACE;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      CARD_TEN:   seg = mode ? SEG_BLANK : SEG_0;
      CARD_JACK:  seg = mode ? SEG_BLANK : SEG_JACK;
      CARD_QUEEN: seg = mode ? SEG_BLANK : SEG_QUEEN;
      CARD_KING:  seg = mode ? SEG_BLANK : SEG_KING;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/card_hand_display.sv
// Hand of up to NUM_CARDS cards with per-slot digits, blinking newest card and baccarat score.
// One-cycle load latency; card_ready drops while full and the producer holds card_valid.
module card_hand_display
  import card_pkg::*;
#(
  parameter int NUM_CARDS  = 3,
  parameter int BLINK_DIV  = 25,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int CW = $clog2(NUM_CARDS + 1)
) (
  input  logic                   slow_clock,
  input  logic                   resetb,
  input  logic                   card_valid,
  input  logic [3:0]             card_in,
  output logic                   card_ready,
  input  logic                   clear,
  input  logic                   blink_en,
  output logic [7*NUM_CARDS-1:0] hex_out,
  output logic [6:0]             hex_score,
  output logic [3:0]             score,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   bad_card
);

  localparam logic [CW-1:0] COUNT_MAX  = CW'(NUM_CARDS);
  localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  card_t         slot [NUM_CARDS];
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic          offer;
  logic          accept;

  assign full       = (count == COUNT_MAX);
  assign card_ready = ~full;
  assign offer      = card_valid && card_ready && !clear;
  assign accept     = offer && card_is_valid(card_in);

  always_ff @(posedge slow_clock) begin
    if (!resetb || clear) begin
      for (int i = 0; i < NUM_CARDS; i++) slot[i] <= '0;
      count     <= '0;
      score     <= '0;
      bad_card  <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      bad_card <= offer && !card_is_valid(card_in);
      if (accept) begin
        for (int i = 0; i < NUM_CARDS; i++) begin
          if (count == CW'(i)) slot[i] <= card_in;
        end
        count     <= count + 1'b1;
        score     <= add_mod10(score, card_points(card_in));
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_en && (count != '0)) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end
    end
  end

  // Empty slots hold code 0, which the card decoder renders blank.
  for (genvar i = 0; i <= NUM_CARDS; i++) begin : g_dig
    if (i < NUM_CARDS) begin : g_slot
      seg_t glyph;
      logic hide;
      card_glyph u_glyph (.mode(1'b0), .code(slot[i]), .seg(glyph));
      assign hide = blink_en && !blink_on && (count == CW'(i + 1));
      assign hex_out[7*i +: 7] = ACTIVE_LOW ? (hide ? SEG_BLANK : glyph)
                                            : ~(hide ? SEG_BLANK : glyph);
    end else begin : g_score
      seg_t glyph;
      card_glyph u_glyph (.mode(1'b1), .code(score), .seg(glyph));
      assign hex_score = ACTIVE_LOW ? ((count == '0) ? SEG_BLANK : glyph)
                                    : ~((count == '0) ? SEG_BLANK : glyph);
    end
  end

endmodule

// File: tb/tb_card_hand_display.sv
// Table-driven scoreboard bench for card_hand_display plus blink and inverted-polarity sequences.
module tb_card_hand_display;

  localparam logic [6:0] BL  = 7'b1111111;
  localparam logic [6:0] D0  = 7'b1000000;
  localparam logic [6:0] D1  = 7'b1111001;
  localparam logic [6:0] GA  = 7'b0001000;
  localparam logic [6:0] G2  = 7'b0100100;
  localparam logic [6:0] G3  = 7'b0110000;
  localparam logic [6:0] G4  = 7'b0011001;
  localparam logic [6:0] G5  = 7'b0010010;
  localparam logic [6:0] G6  = 7'b0000010;
  localparam logic [6:0] G7  = 7'b1111000;
  localparam logic [6:0] G8  = 7'b0000000;
  localparam logic [6:0] G9  = 7'b0010000;
  localparam logic [6:0] G10 = 7'b1000000;
  localparam logic [6:0] GJ  = 7'b1100001;
  localparam logic [6:0] GQ  = 7'b0011000;
  localparam logic [6:0] GK  = 7'b0001001;

  logic slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  logic        resetb, card_valid, clear, blink_en;
  logic [3:0]  card_in;
  logic        card_ready, full, bad_card;
  logic [20:0] hex_out;
  logic [6:0]  hex_score;
  logic [3:0]  score;
  logic [1:0]  count;
  logic        card_ready_n, full_n, bad_card_n;
  logic [20:0] hex_out_n;
  logic [6:0]  hex_score_n;
  logic [3:0]  score_n;
  logic [1:0]  count_n;

  card_hand_display #(.NUM_CARDS(3), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .card_valid(card_valid), .card_in(card_in),
    .card_ready(card_ready), .clear(clear), .blink_en(blink_en), .hex_out(hex_out),
    .hex_score(hex_score), .score(score), .count(count), .full(full), .bad_card(bad_card)
  );

  card_hand_display #(.NUM_CARDS(3), .BLINK_DIV(4), .ACTIVE_LOW(1'b0)) dut_pos (
    .slow_clock(slow_clock), .resetb(resetb), .card_valid(card_valid), .card_in(card_in),
    .card_ready(card_ready_n), .clear(clear), .blink_en(blink_en), .hex_out(hex_out_n),
    .hex_score(hex_score_n), .score(score_n), .count(count_n), .full(full_n),
    .bad_card(bad_card_n)
  );

  typedef struct {
    logic        rb, v, clr;
    logic [3:0]  card;
    logic [1:0]  cnt;
    logic [3:0]  sc;
    logic        bad;
    logic [20:0] hx;
    logic [6:0]  hs;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic rb, input logic v, input logic clr, input logic [3:0] card,
                              input logic [1:0] cnt, input logic [3:0] sc, input logic bad,
                              input logic [20:0] hx, input logic [6:0] hs);
    vec_t r;
    r.rb = rb; r.v = v; r.clr = clr; r.card = card;
    r.cnt = cnt; r.sc = sc; r.bad = bad; r.hx = hx; r.hs = hs;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  initial begin
    vec_t e;
    resetb = 1'b0; card_valid = 1'b0; card_in = 4'd0; clear = 1'b0; blink_en = 1'b0;

    vecs.push_back(mk(0, 0, 0, 4'd0,  0, 0, 0, {BL, BL, BL}, BL));
    vecs.push_back(mk(0, 0, 0, 4'd0,  0, 0, 0, {BL, BL, BL}, BL));
    vecs.push_back(mk(1, 0, 0, 4'd0,  0, 0, 0, {BL, BL, BL}, BL));
    vecs.push_back(mk(1, 1, 0, 4'd7,  1, 7, 0, {BL, BL, G7}, G7));
    vecs.push_back(mk(1, 1, 0, 4'd8,  2, 5, 0, {BL, G8, G7}, G5));
    vecs.push_back(mk(1, 0, 1, 4'd0,  0, 0, 0, {BL, BL, BL}, BL));
    vecs.push_back(mk(1, 1, 0, 4'd13, 1, 0, 0, {BL, BL, GK}, D0));
    vecs.push_back(mk(1, 1, 0, 4'd9,  2, 9, 0, {BL, G9, GK}, G9));
    vecs.push_back(mk(1, 1, 0, 4'd1,  3, 0, 0, {GA, G9, GK}, D0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 0, 4'd12, 3, 0, 0, {GA, G9, GK}, D0));
    vecs.push_back(mk(1, 0, 1, 4'd0,  0, 0, 0, {BL, BL, BL}, BL));
    vecs.push_back(mk(1, 1, 0, 4'd14, 0, 0, 1, {BL, BL, BL}, BL));
    vecs.push_back(mk(1, 0, 0, 4'd0,  0, 0, 0, {BL, BL, BL}, BL));
    vecs.push_back(mk(1, 1, 0, 4'd5,  1, 5, 0, {BL, BL, G5}, G5));
    vecs.push_back(mk(1, 1, 0, 4'd15, 1, 5, 1, {BL, BL, G5}, G5));
    vecs.push_back(mk(1, 1, 0, 4'd0,  1, 5, 1, {BL, BL, G5}, G5));
    vecs.push_back(mk(1, 1, 1, 4'd5,  0, 0, 0, {BL, BL, BL}, BL));
    vecs.push_back(mk(1, 1, 0, 4'd10, 1, 0, 0, {BL, BL, G10}, D0));
    vecs.push_back(mk(1, 1, 0, 4'd12, 2, 0, 0, {BL, GQ, G10}, D0));
    vecs.push_back(mk(1, 1, 0, 4'd6,  3, 6, 0, {G6, GQ, G10}, G6));
    vecs.push_back(mk(1, 1, 0, 4'd4,  3, 6, 0, {G6, GQ, G10}, G6));
    vecs.push_back(mk(1, 1, 0, 4'd15, 3, 6, 0, {G6, GQ, G10}, G6));
    vecs.push_back(mk(1, 0, 1, 4'd0,  0, 0, 0, {BL, BL, BL}, BL));
    vecs.push_back(mk(1, 1, 0, 4'd3,  1, 3, 0, {BL, BL, G3}, G3));
    vecs.push_back(mk(1, 1, 0, 4'd4,  2, 7, 0, {BL, G4, G3}, G7));
    vecs.push_back(mk(1, 1, 0, 4'd4,  3, 1, 0, {G4, G4, G3}, D1));
    vecs.push_back(mk(1, 0, 1, 4'd0,  0, 0, 0, {BL, BL, BL}, BL));
    vecs.push_back(mk(1, 1, 0, 4'd2,  1, 2, 0, {BL, BL, G2}, G2));
    vecs.push_back(mk(1, 1, 0, 4'd6,  2, 8, 0, {BL, G6, G2}, G8));
    vecs.push_back(mk(1, 1, 0, 4'd11, 3, 8, 0, {GJ, G6, G2}, G8));
    vecs.push_back(mk(0, 1, 0, 4'd5,  0, 0, 0, {BL, BL, BL}, BL));

    foreach (vecs[i]) begin
      resetb = vecs[i].rb; card_valid = vecs[i].v; clear = vecs[i].clr; card_in = vecs[i].card;
      sb.push_back(vecs[i]);
      tick();
      if (sb.size() == 0) begin
        check($sformatf("v%0d_scoreboard_empty", i), 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_count", i), 32'(count), 32'(e.cnt));
        check($sformatf("v%0d_score", i), 32'(score), 32'(e.sc));
        check($sformatf("v%0d_bad_card", i), 32'(bad_card), 32'(e.bad));
        check($sformatf("v%0d_hex_out", i), 32'(hex_out), 32'(e.hx));
        check($sformatf("v%0d_hex_score", i), 32'(hex_score), 32'(e.hs));
        check($sformatf("v%0d_full", i), 32'(full), 32'(e.cnt == 2'd3));
        check($sformatf("v%0d_card_ready", i), 32'(card_ready), 32'(e.cnt != 2'd3));
      end
    end

    // Blink: single jack toggles every 4 cycles, starting shown right after the accept.
    resetb = 1'b1; card_valid = 1'b1; card_in = 4'd11; blink_en = 1'b1;
    tick();
    card_valid = 1'b0;
    for (int k = 0; k < 14; k++) begin
      check($sformatf("blink_j_k%0d", k), 32'(hex_out[6:0]), 32'(((k / 4) % 2 == 0) ? GJ : BL));
      tick();
    end
    check("blink_j_k14_blank", 32'(hex_out[6:0]), 32'(BL));
    // Accept during the blank phase restarts blinking on the new card only.
    card_valid = 1'b1; card_in = 4'd3;
    tick();
    card_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("blink_3_slot1_j%0d", j), 32'(hex_out[13:7]), 32'((j < 4) ? G3 : BL));
      check($sformatf("blink_3_slot0_j%0d", j), 32'(hex_out[6:0]), 32'(GJ));
      check($sformatf("blink_3_score_j%0d", j), 32'(hex_score), 32'(G3));
      tick();
    end

    // Inverted polarity instance.
    blink_en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; card_valid = 1'b1; card_in = 4'd2;
    tick();
    card_valid = 1'b0;
    check("pos_slot_two", 32'(hex_out_n), 32'({7'b0000000, 7'b0000000, 7'b1011011}));
    check("pos_score_two", 32'(hex_score_n), 32'(7'b1011011));
    check("pos_count", 32'(count_n), 32'd1);
    blink_en = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    check("pos_blink_blank", 32'(hex_out_n[6:0]), 32'(7'b0000000));
    check("neg_blink_blank", 32'(hex_out[6:0]), 32'(BL));
    resetb = 1'b0; card_valid = 1'b1; card_in = 4'd5;
    tick();
    check("pos_reset_hex", 32'(hex_out_n), 32'd0);
    check("pos_reset_score_glyph", 32'(hex_score_n), 32'd0);
    check("pos_reset_count", 32'(count_n), 32'd0);
    check("neg_reset_hex", 32'(hex_out), 32'({BL, BL, BL}));
    check("neg_reset_ready", 32'(card_ready), 32'd1);
    resetb = 1'b1; card_valid = 1'b0;
    tick();
    check("pos_idle_hex", 32'(hex_out_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
